// File: rtl/pipelined_main_decoder.sv
// rtl/pipelined_main_decoder.sv - decode-stage control generator with ID/EX register and mul/div stall FSM
module pipelined_main_decoder #(
   parameter int IMM_SRC_WIDTH = 3,
   parameter int ALU_OP_WIDTH  = 3,
   parameter int OP_WIDTH      = 7,
   parameter int MULDIV_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     InstrValidD,
   input  logic [31:0]              InstrD,
   input  logic                     StallE,
   input  logic                     FlushE,
   output logic                     StallD,
   output logic                     ValidE,
   output logic                     RegWriteE,
   output logic [IMM_SRC_WIDTH-1:0] ImmSrcE,
   output logic                     ALUSrcE,
   output logic                     MemWriteE,
   output logic                     MemReadE,
   output logic [1:0]               ResultSrcE,
   output logic                     BranchE,
   output logic                     JumpE,
   output logic                     JalrE,
   output logic [ALU_OP_WIDTH-1:0]  ALUOpE,
   output logic                     MulDivE,
   output logic                     IllegalE
);

   localparam logic [OP_WIDTH-1:0] OP_LOAD   = OP_WIDTH'(7'b0000011);
   localparam logic [OP_WIDTH-1:0] OP_STORE  = OP_WIDTH'(7'b0100011);
   localparam logic [OP_WIDTH-1:0] OP_REG    = OP_WIDTH'(7'b0110011);
   localparam logic [OP_WIDTH-1:0] OP_IMM    = OP_WIDTH'(7'b0010011);
   localparam logic [OP_WIDTH-1:0] OP_BRANCH = OP_WIDTH'(7'b1100011);
   localparam logic [OP_WIDTH-1:0] OP_AUIPC  = OP_WIDTH'(7'b0010111);
   localparam logic [OP_WIDTH-1:0] OP_LUI    = OP_WIDTH'(7'b0110111);
   localparam logic [OP_WIDTH-1:0] OP_JALR   = OP_WIDTH'(7'b1100111);
   localparam logic [OP_WIDTH-1:0] OP_JAL    = OP_WIDTH'(7'b1101111);

   localparam logic [IMM_SRC_WIDTH-1:0] IMM_I = IMM_SRC_WIDTH'(3'b000);
   localparam logic [IMM_SRC_WIDTH-1:0] IMM_S = IMM_SRC_WIDTH'(3'b001);
   localparam logic [IMM_SRC_WIDTH-1:0] IMM_B = IMM_SRC_WIDTH'(3'b010);
   localparam logic [IMM_SRC_WIDTH-1:0] IMM_U = IMM_SRC_WIDTH'(3'b011);
   localparam logic [IMM_SRC_WIDTH-1:0] IMM_J = IMM_SRC_WIDTH'(3'b100);

   localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD   = ALU_OP_WIDTH'(3'b000);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_BCMP  = ALU_OP_WIDTH'(3'b001);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_FUNCT = ALU_OP_WIDTH'(3'b010);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_JALR  = ALU_OP_WIDTH'(3'b011);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_UPPER = ALU_OP_WIDTH'(3'b100);

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   // Occupancy beyond the first EX cycle is what decode has to wait out.
   localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 1);

   typedef struct packed {
      logic                     regwrite;
      logic [IMM_SRC_WIDTH-1:0] immsrc;
      logic                     alusrc;
      logic                     memwrite;
      logic                     memread;
      logic [1:0]               resultsrc;
      logic                     branch;
      logic                     jump;
      logic                     jalr;
      logic [ALU_OP_WIDTH-1:0]  aluop;
      logic                     muldiv;
      logic                     illegal;
   } ctrl_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   logic [OP_WIDTH-1:0] op;
   logic [6:0]          funct7;
   logic                unused_fields;

   ctrl_t  dec;
   ctrl_t  bundle_q;
   logic   valid_q;
   state_t state_q;
   state_t state_d;
   logic [3:0] cnt_q;
   logic [3:0] cnt_d;
   logic   load_en;

   assign op            = InstrD[OP_WIDTH-1:0];
   assign funct7        = InstrD[31:25];
   // funct3 and the register/immediate fields do not influence the control bundle.
   assign unused_fields = ^InstrD[24:OP_WIDTH];

   // Combinational decode table; a non-valid slot decodes as an all-zero bubble.
   always_comb begin
      dec = '0;
      if (InstrValidD) begin
         case (op)
            OP_LOAD: begin
               dec.regwrite  = 1'b1;
               dec.immsrc    = IMM_I;
               dec.alusrc    = 1'b1;
               dec.memread   = 1'b1;
               dec.resultsrc = 2'b01;
               dec.aluop     = ALU_ADD;
            end
            OP_STORE: begin
               dec.immsrc    = IMM_S;
               dec.alusrc    = 1'b1;
               dec.memwrite  = 1'b1;
               dec.aluop     = ALU_ADD;
            end
            OP_REG: begin
               dec.regwrite  = 1'b1;
               dec.aluop     = ALU_FUNCT;
               dec.muldiv    = (funct7 == FUNCT7_MULDIV);
            end
            OP_IMM: begin
               dec.regwrite  = 1'b1;
               dec.immsrc    = IMM_I;
               dec.alusrc    = 1'b1;
               dec.aluop     = ALU_FUNCT;
            end
            OP_BRANCH: begin
               dec.immsrc    = IMM_B;
               dec.branch    = 1'b1;
               dec.aluop     = ALU_BCMP;
            end
            OP_AUIPC: begin
               dec.regwrite  = 1'b1;
               dec.immsrc    = IMM_U;
               dec.alusrc    = 1'b1;
               dec.resultsrc = 2'b10;
               dec.aluop     = ALU_UPPER;
            end
            OP_LUI: begin
               dec.regwrite  = 1'b1;
               dec.immsrc    = IMM_U;
               dec.alusrc    = 1'b1;
               dec.resultsrc = 2'b00;
               dec.aluop     = ALU_UPPER;
            end
            OP_JALR: begin
               dec.regwrite  = 1'b1;
               dec.immsrc    = IMM_I;
               dec.alusrc    = 1'b1;
               dec.resultsrc = 2'b10;
               dec.jump      = 1'b1;
               dec.jalr      = 1'b1;
               dec.aluop     = ALU_JALR;
            end
            OP_JAL: begin
               dec.regwrite  = 1'b1;
               dec.immsrc    = IMM_J;
               dec.resultsrc = 2'b11;
               dec.jump      = 1'b1;
               dec.aluop     = ALU_UPPER;
            end
            default: begin
               dec.illegal   = 1'b1;
            end
         endcase
      end
   end

   assign StallD  = (state_q == BUSY);
   // A fresh instruction enters EX only when nothing of higher priority claims the edge.
   assign load_en = !FlushE && !StallE && !StallD;

   // ID/EX register: flush beats stall beats mul/div bubble beats load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         bundle_q <= '0;
      end else if (FlushE) begin
         valid_q  <= 1'b0;
         bundle_q <= '0;
      end else if (StallE) begin
         valid_q  <= valid_q;
         bundle_q <= bundle_q;
      end else if (StallD) begin
         valid_q  <= 1'b0;
         bundle_q <= '0;
      end else begin
         valid_q  <= InstrValidD;
         bundle_q <= dec;
      end
   end

   // Mul/div occupancy FSM state and countdown register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: enter BUSY when a mul/div loads, count down unfrozen cycles, leave on flush or last count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (load_en && dec.muldiv && (MULDIV_CYCLES > 1)) begin
               state_d = BUSY;
               cnt_d   = CNT_LOAD;
            end
         end
         BUSY: begin
            if (FlushE) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (!StallE) begin
               if (cnt_q <= 4'd1) begin
                  state_d = IDLE;
                  cnt_d   = 4'd0;
               end else begin
                  cnt_d   = cnt_q - 4'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   assign ValidE     = valid_q;
   assign RegWriteE  = bundle_q.regwrite;
   assign ImmSrcE    = bundle_q.immsrc;
   assign ALUSrcE    = bundle_q.alusrc;
   assign MemWriteE  = bundle_q.memwrite;
   assign MemReadE   = bundle_q.memread;
   assign ResultSrcE = bundle_q.resultsrc;
   assign BranchE    = bundle_q.branch;
   assign JumpE      = bundle_q.jump;
   assign JalrE      = bundle_q.jalr;
   assign ALUOpE     = bundle_q.aluop;
   assign MulDivE    = bundle_q.muldiv;
   assign IllegalE   = bundle_q.illegal;

endmodule

// File: tb/tb_pipelined_main_decoder.sv
// tb/tb_pipelined_main_decoder.sv - scoreboard bench for pipelined_main_decoder
module tb_pipelined_main_decoder;

   localparam int MULDIV_CYCLES = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        InstrValidD;
   logic [31:0] InstrD;
   logic        StallE;
   logic        FlushE;
   logic        StallD;
   logic        ValidE;
   logic        RegWriteE;
   logic [2:0]  ImmSrcE;
   logic        ALUSrcE;
   logic        MemWriteE;
   logic        MemReadE;
   logic [1:0]  ResultSrcE;
   logic        BranchE;
   logic        JumpE;
   logic        JalrE;
   logic [2:0]  ALUOpE;
   logic        MulDivE;
   logic        IllegalE;

   pipelined_main_decoder #(
      .IMM_SRC_WIDTH(3),
      .ALU_OP_WIDTH(3),
      .OP_WIDTH(7),
      .MULDIV_CYCLES(MULDIV_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .InstrValidD(InstrValidD), .InstrD(InstrD),
      .StallE(StallE), .FlushE(FlushE), .StallD(StallD), .ValidE(ValidE),
      .RegWriteE(RegWriteE), .ImmSrcE(ImmSrcE), .ALUSrcE(ALUSrcE),
      .MemWriteE(MemWriteE), .MemReadE(MemReadE), .ResultSrcE(ResultSrcE),
      .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .ALUOpE(ALUOpE),
      .MulDivE(MulDivE), .IllegalE(IllegalE)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Observed vector: {valid, stalld, regwrite, immsrc[3], alusrc, memwrite, memread, resultsrc[2], branch, jump, jalr, aluop[3], muldiv, illegal}
   logic [18:0] sb[$];
   logic        mon_en = 1'b0;

   logic        m_valid;
   logic [16:0] m_bundle;
   int          busy_left;

   function automatic logic [18:0] observed();
      return {ValidE, StallD, RegWriteE, ImmSrcE, ALUSrcE, MemWriteE, MemReadE,
              ResultSrcE, BranchE, JumpE, JalrE, ALUOpE, MulDivE, IllegalE};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [16:0] row(input logic rw, input logic [2:0] imm, input logic as,
                                       input logic mw, input logic mr, input logic [1:0] rs,
                                       input logic br, input logic j, input logic jr,
                                       input logic [2:0] aop, input logic md, input logic il);
      return {rw, imm, as, mw, mr, rs, br, j, jr, aop, md, il};
   endfunction

   // Reference decode straight from the opcode table.
   function automatic logic [16:0] ref_decode(input logic v, input logic [31:0] ins);
      logic md;
      if (!v) return '0;
      md = (ins[31:25] == 7'b0000001);
      case (ins[6:0])
         7'b0000011: return row(1, 3'd0, 1, 0, 1, 2'b01, 0, 0, 0, 3'd0, 0, 0);
         7'b0100011: return row(0, 3'd1, 1, 1, 0, 2'b00, 0, 0, 0, 3'd0, 0, 0);
         7'b0110011: return row(1, 3'd0, 0, 0, 0, 2'b00, 0, 0, 0, 3'd2, md, 0);
         7'b0010011: return row(1, 3'd0, 1, 0, 0, 2'b00, 0, 0, 0, 3'd2, 0, 0);
         7'b1100011: return row(0, 3'd2, 0, 0, 0, 2'b00, 1, 0, 0, 3'd1, 0, 0);
         7'b0010111: return row(1, 3'd3, 1, 0, 0, 2'b10, 0, 0, 0, 3'd4, 0, 0);
         7'b0110111: return row(1, 3'd3, 1, 0, 0, 2'b00, 0, 0, 0, 3'd4, 0, 0);
         7'b1100111: return row(1, 3'd0, 1, 0, 0, 2'b10, 0, 1, 1, 3'd3, 0, 0);
         7'b1101111: return row(1, 3'd4, 0, 0, 0, 2'b11, 0, 1, 0, 3'd4, 0, 0);
         default:    return row(0, 3'd0, 0, 0, 0, 2'b00, 0, 0, 0, 3'd0, 0, 1);
      endcase
   endfunction

   function automatic logic is_muldiv(input logic v, input logic [31:0] ins);
      return v && (ins[6:0] == 7'b0110011) && (ins[31:25] == 7'b0000001);
   endfunction

   task automatic model_reset();
      m_valid   = 1'b0;
      m_bundle  = '0;
      busy_left = 0;
   endtask

   // Drive one cycle of inputs, advance the reference at the edge and queue its expectation.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic se, input logic fe);
      InstrValidD = v;
      InstrD      = ins;
      StallE      = se;
      FlushE      = fe;
      @(posedge clk);
      if (fe) begin
         m_valid = 1'b0; m_bundle = '0; busy_left = 0;
      end else if (se) begin
         // EX frozen: bundle and remaining occupancy both hold
      end else if (busy_left > 0) begin
         m_valid = 1'b0; m_bundle = '0; busy_left--;
      end else begin
         m_valid  = v;
         m_bundle = ref_decode(v, ins);
         if (is_muldiv(v, ins) && MULDIV_CYCLES > 1) busy_left = MULDIV_CYCLES - 1;
      end
      sb.push_back({m_valid, (busy_left > 0), m_bundle});
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [6:0]  ops[11];
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0110011, 7'b0010011, 7'b1100011,
              7'b0010111, 7'b0110111, 7'b1100111, 7'b1101111, 7'b1111111};
      w = $urandom;
      if ($urandom_range(0, 9) == 0) w[6:0] = 7'($urandom);
      else w[6:0] = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 1) == 1) w[31:25] = 7'b0000001;
      return w;
   endfunction

   // Monitor: every cycle the DUT presents a registered bundle; pop and compare.
   always @(negedge clk) begin
      if (mon_en && sb.size() > 0) begin
         logic [18:0] e;
         e = sb.pop_front();
         check("bundle", 32'(observed()), 32'(e));
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int stall_cnt;
      rst = 1'b1; InstrValidD = 1'b0; InstrD = '0; StallE = 1'b0; FlushE = 1'b0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      check("reset_outputs", 32'(observed()), 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;

      // addi, jal, jalr, illegal opcode
      cycle(1, 32'h00A00093, 0, 0);
      check("addi_ctrl", {ValidE, RegWriteE, ALUSrcE, ALUOpE}, {1'b1, 1'b1, 1'b1, 3'b010});
      cycle(1, 32'h0000006F, 0, 0);
      check("jal_ctrl", {JumpE, BranchE, ResultSrcE, ImmSrcE}, {1'b1, 1'b0, 2'b11, 3'b100});
      cycle(1, 32'h00008067, 0, 0);
      check("jalr_ctrl", {JalrE, JumpE}, 2'b11);
      cycle(1, 32'h0000007F, 0, 0);
      check("illegal_ctrl", {IllegalE, ValidE, RegWriteE, MemWriteE, JumpE}, 5'b11000);
      cycle(0, 32'h00000000, 0, 0);

      // lw then simultaneous flush and stall: flush must win
      cycle(1, 32'h00002083, 0, 0);
      cycle(1, 32'h00A00093, 1, 1);
      check("flush_over_stall", {ValidE, MemReadE}, 2'b00);

      // mul: decode stalls for MULDIV_CYCLES-1 cycles while EX gets bubbles
      cycle(1, 32'h02208033, 0, 0);
      check("mul_muldive", {MulDivE, ValidE}, 2'b11);
      stall_cnt = StallD ? 1 : 0;
      for (int i = 0; i < 5; i++) begin
         cycle(1, 32'h00A00093, 0, 0);
         if (StallD) stall_cnt++;
      end
      check("mul_stall_cycles", 32'(stall_cnt), 32'(MULDIV_CYCLES - 1));

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         cycle($urandom_range(0, 7) != 0, rand_instr(),
               $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      end

      // reset asserted mid-BUSY clears everything before the next edge
      cycle(1, 32'h02208033, 0, 0);
      cycle(1, 32'h00A00093, 0, 0);
      check("busy_before_rst", 32'(StallD), 32'd1);
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      check("async_rst_clear", 32'(observed()), 32'd0);
      sb.delete();
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      mon_en = 1'b1;
      cycle(1, 32'h00A00093, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 32'h0, 0, 0);

      @(negedge clk); #1;
      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
      $finish;
   end

endmodule
